clock_div_ctrl: RTL and testbench
=================================

CLOCK_DIV_CTRL -- requirements
Module: clock_div_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the divisor and internal counter.
REQ-002 SHALL have parameter RESET_DIV, default 100, active divisor loaded at reset.
REQ-003 SHALL have port clk_in  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port run  input  1  level request to generate the divided clock.
REQ-006 SHALL have port cfg_valid  input  1  new divisor offered.
REQ-007 SHALL have port cfg_div  input  DATA_WIDTH  offered divisor value.
REQ-008 SHALL have port cfg_ready  output  1  divisor can be accepted this cycle.
REQ-009 SHALL have port clk_out  output  1  divided clock, registered.
REQ-010 SHALL have port tick  output  1  one-cycle pulse on every clk_out toggle.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL implement states IDLE, RUN, STOPPING; pending-divisor flag is independent of state.
REQ-013 SHALL count 0..div_active in RUN/STOPPING; terminal count (cnt==div_active) -> cnt<=0, clk_out toggles, tick=1 that cycle; period = 2*(div_active+1) cycles.
REQ-014 div_active=0 SHALL toggle clk_out every cycle; arithmetic is unsigned, counter never exceeds div_active.
REQ-015 IDLE: cnt=0, clk_out=0, tick=0; run=1 -> RUN next cycle, first toggle (to 1) after div_active+1 RUN cycles.
REQ-016 RUN, run=0, clk_out=0 -> IDLE next cycle, cnt cleared, no tick.
REQ-017 RUN, run=0, clk_out=1 -> STOPPING; counting continues; at terminal count clk_out falls, tick=1, -> IDLE.
REQ-018 STOPPING, run=1 -> RUN with no disturbance to cnt or clk_out.
REQ-019 Handshake: transfer when cfg_valid && cfg_ready; cfg_ready = !pending.
REQ-020 Transfer in IDLE SHALL write div_active directly next cycle; no pending set.
REQ-021 Transfer in RUN/STOPPING SHALL store cfg_div to div_pending, set pending; applied (div_active<=div_pending, pending cleared) at the next terminal count or on entry to IDLE, whichever first.
REQ-022 Transfer coinciding with terminal count SHALL be pending and applied at the following terminal count (no same-cycle bypass).
REQ-023 cfg_ready SHALL reassert the cycle after pending clears.
REQ-024 clk_out SHALL never change except at terminal count; no runt half-periods other than the truncated low phase of REQ-016.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, cnt=0, clk_out=0, tick=0, pending=0, cfg_ready=1, busy=0, div_active=RESET_DIV, regardless of state.
REQ-026 Reset mid-transfer or mid-period SHALL discard the pending divisor.

Configuration
REQ-027 Macro CLOCK_DIV_CTRL_TICK_COUNT_EN defined: SHALL add output tick_cnt (DATA_WIDTH) counting ticks since reset, wrapping at 2^DATA_WIDTH to 0, reset 0.
REQ-028 Macro undefined: port tick_cnt and its counter SHALL be absent; all other behaviour identical.

Structure
REQ-029 Shared package clock_div_pkg SHALL hold the state enum type and the default divisor constant.
REQ-030 Counter plus toggle SHALL be sub-module div_counter (inputs enable, clear, div; outputs terminal, clk_out); controller holds FSM and handshake.

Verification
REQ-031 Reset, cfg div=3, run=1 -> first clk_out rise 4 cycles after RUN entry, period 8, tick every 4 cycles.
REQ-032 RUN div=3, offer div=1 mid-period -> cfg_ready low until next terminal count, then period 4; second offer held off while pending.
REQ-033 run=0 while clk_out=1 at cnt=1, div=3 -> STOPPING, clk_out falls 2 cycles later with tick, IDLE, busy=0.
REQ-034 run=0 then run=1 one cycle later in STOPPING -> back to RUN, waveform continuous, no extra tick.
REQ-035 div=0 -> clk_out toggles every cycle, tick constant high while running.
REQ-036 rst_n low mid-period with pending set -> all outputs at reset values asynchronously, div_active=100; with macro, tick_cnt=0.

Source files
------------

// File: rtl/clock_div_pkg.sv
// Shared types and constants for the clock divider controller.
// Optional feature macro: CLOCK_DIV_CTRL_TICK_COUNT_EN (adds tick_cnt output).
package clock_div_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_STOPPING = 2'd2
   } state_t;

   localparam int unsigned DEFAULT_DIV = 100;

endpackage

// File: rtl/clock_div_ctrl_div_counter.sv
// Up-counter 0..div with output toggle at terminal count.
// terminal is the raw count match; the counter only acts on it when enabled.
module div_counter
   import clock_div_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk_in,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] div,
   output logic                  terminal,
   output logic                  clk_out
);

   localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

   logic [DATA_WIDTH-1:0] cnt;

   assign terminal = (cnt == div);

   // Count while enabled; wrap and toggle the output at terminal count.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         clk_out <= 1'b0;
      end else if (clear) begin
         cnt     <= '0;
         clk_out <= 1'b0;
      end else if (enable) begin
         if (terminal) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
         end else begin
            cnt <= cnt + ONE;
         end
      end
   end

endmodule

// File: rtl/clock_div_ctrl.sv
// Clock divider controller: run/stop FSM plus divisor handshake.
// Optional feature macro: CLOCK_DIV_CTRL_TICK_COUNT_EN adds tick_cnt,
// a wrapping count of ticks since reset.
module clock_div_ctrl
   import clock_div_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned RESET_DIV  = DEFAULT_DIV
) (
   input  logic                  clk_in,
   input  logic                  rst_n,
   input  logic                  run,
   input  logic                  cfg_valid,
   input  logic [DATA_WIDTH-1:0] cfg_div,
   output logic                  cfg_ready,
   output logic                  clk_out,
   output logic                  tick,
   output logic                  busy
`ifdef CLOCK_DIV_CTRL_TICK_COUNT_EN
   ,
   output logic [DATA_WIDTH-1:0] tick_cnt
`endif
);

   state_t                state;
   state_t                next_state;
   logic                  cnt_enable;
   logic                  cnt_clear;
   logic                  terminal;
   logic [DATA_WIDTH-1:0] div_active;
   logic [DATA_WIDTH-1:0] div_pending;
   logic                  pending;
   logic                  xfer;
   logic                  apply;

   div_counter #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_counter (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .enable   (cnt_enable),
      .clear    (cnt_clear),
      .div      (div_active),
      .terminal (terminal),
      .clk_out  (clk_out)
   );

   assign tick      = cnt_enable && terminal;
   assign busy      = (state != ST_IDLE);
   assign cfg_ready = !pending;
   assign xfer      = cfg_valid && !pending;
   // A divisor transferred this cycle is not yet pending, so it cannot bypass
   // to a coinciding terminal count.
   assign apply     = pending && (tick || state == ST_IDLE || next_state == ST_IDLE);

   // State register.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and counter control.
   always_comb begin
      next_state = state;
      cnt_enable = 1'b0;
      cnt_clear  = 1'b0;
      case (state)
         ST_IDLE: begin
            cnt_clear = 1'b1;
            if (run) begin
               next_state = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!run && !clk_out) begin
               // Low phase may be truncated: stop at once, no tick.
               cnt_clear  = 1'b1;
               next_state = ST_IDLE;
            end else begin
               cnt_enable = 1'b1;
               if (!run) begin
                  // High phase must complete; if it ends now, go straight idle.
                  next_state = terminal ? ST_IDLE : ST_STOPPING;
               end
            end
         end
         ST_STOPPING: begin
            cnt_enable = 1'b1;
            if (run) begin
               next_state = ST_RUN;
            end else if (terminal) begin
               next_state = ST_IDLE;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Divisor handshake: direct load when idle, deferred load while running.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         div_active  <= DATA_WIDTH'(RESET_DIV);
         div_pending <= '0;
         pending     <= 1'b0;
      end else begin
         if (apply) begin
            div_active <= div_pending;
            pending    <= 1'b0;
         end
         if (xfer) begin
            if (state == ST_IDLE) begin
               div_active <= cfg_div;
            end else begin
               div_pending <= cfg_div;
               pending     <= 1'b1;
            end
         end
      end
   end

`ifdef CLOCK_DIV_CTRL_TICK_COUNT_EN
   localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

   // Ticks since reset, wrapping naturally.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= tick_cnt + ONE;
      end
   end
`endif

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Randomized scoreboard bench for clock_div_ctrl against a countdown model.
module tb_clock_div_ctrl;

   localparam int unsigned W = 32;

   logic         clk_in = 1'b0;
   logic         rst_n;
   logic         run;
   logic         cfg_valid;
   logic [W-1:0] cfg_div;
   logic         cfg_ready;
   logic         clk_out;
   logic         tick;
   logic         busy;
`ifdef CLOCK_DIV_CTRL_TICK_COUNT_EN
   logic [W-1:0] tick_cnt;
`endif

   always #5 clk_in = ~clk_in;

   clock_div_ctrl #(
      .DATA_WIDTH (W),
      .RESET_DIV  (100)
   ) dut (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .run       (run),
      .cfg_valid (cfg_valid),
      .cfg_div   (cfg_div),
      .cfg_ready (cfg_ready),
      .clk_out   (clk_out),
      .tick      (tick),
      .busy      (busy)
`ifdef CLOCK_DIV_CTRL_TICK_COUNT_EN
      ,
      .tick_cnt  (tick_cnt)
`endif
   );

   typedef struct {
      logic         clk_out;
      logic         tick;
      logic         busy;
      logic         ready;
      logic [W-1:0] tcnt;
   } exp_t;

   exp_t        sb[$];
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   // Reference model: cycles-until-toggle countdown, not a counter replica.
   bit           m_active;
   bit           m_level;
   int unsigned  m_left;
   int unsigned  m_div;
   int unsigned  m_pdiv;
   bit           m_have_p;
   logic [W-1:0] m_tcnt;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_active = 0;
      m_level  = 0;
      m_left   = 0;
      m_div    = 100;
      m_pdiv   = 0;
      m_have_p = 0;
      m_tcnt   = '0;
   endtask

   // Predict this cycle's outputs, queue them, then advance the model.
   task automatic model_step(input bit r, input bit v, input int unsigned d);
      exp_t e;
      bit   counting, tick_now, go_idle, xfer;
      counting = m_active && (r || m_level);
      tick_now = counting && (m_left == 1);
      e.clk_out = m_level;
      e.tick    = tick_now;
      e.busy    = m_active;
      e.ready   = !m_have_p;
      e.tcnt    = m_tcnt;
      sb.push_back(e);
      xfer = v && !m_have_p;
      if (!m_active) begin
         if (m_have_p) begin
            m_div    = m_pdiv;
            m_have_p = 0;
         end
         if (xfer) m_div = d;
         if (r) begin
            m_active = 1;
            m_left   = m_div + 1;
         end
      end else begin
         go_idle = !r && (!m_level || tick_now);
         if (m_have_p && (tick_now || go_idle)) begin
            m_div    = m_pdiv;
            m_have_p = 0;
         end
         if (xfer) begin
            m_pdiv   = d;
            m_have_p = 1;
         end
         if (tick_now) begin
            m_level = !m_level;
            m_left  = m_div + 1;
            m_tcnt  = m_tcnt + 1;
         end else if (counting) begin
            m_left = m_left - 1;
         end
         if (go_idle) begin
            m_active = 0;
            m_level  = 0;
         end
      end
   endtask

   task automatic cycle(input bit r, input bit v, input int unsigned d);
      @(posedge clk_in);
      #1;
      run       = r;
      cfg_valid = v;
      cfg_div   = W'(d);
      model_step(r, v, d);
   endtask

   // Assert reset between edges and check outputs respond without a clock.
   task automatic do_reset();
      @(negedge clk_in);
      #2;
      rst_n     = 1'b0;
      run       = 1'b0;
      cfg_valid = 1'b0;
      #1;
      check("rst_clk_out", W'(clk_out), '0);
      check("rst_tick", W'(tick), '0);
      check("rst_busy", W'(busy), '0);
      check("rst_cfg_ready", W'(cfg_ready), W'(1));
`ifdef CLOCK_DIV_CTRL_TICK_COUNT_EN
      check("rst_tick_cnt", tick_cnt, '0);
`endif
      model_reset();
      @(posedge clk_in);
      @(negedge clk_in);
      rst_n = 1'b1;
   endtask

   // Monitor: every cycle the DUT presents outputs, compare against the queue.
   always @(negedge clk_in) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("clk_out", W'(clk_out), W'(e.clk_out));
         check("tick", W'(tick), W'(e.tick));
         check("busy", W'(busy), W'(e.busy));
         check("cfg_ready", W'(cfg_ready), W'(e.ready));
`ifdef CLOCK_DIV_CTRL_TICK_COUNT_EN
         check("tick_cnt", tick_cnt, e.tcnt);
`endif
      end
   end

   initial begin
      bit          r;
      bit          v;
      int unsigned d;
      rst_n     = 1'b0;
      run       = 1'b0;
      cfg_valid = 1'b0;
      cfg_div   = '0;
      do_reset();

      // Reset divisor: first rise after 101 running cycles, fall 101 later.
      for (int i = 0; i < 210; i++) cycle(1'b1, 1'b0, 0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 0);

      // Idle load of divisor 3, then a mid-period offer of 1 and a held-off second offer.
      cycle(1'b0, 1'b1, 3);
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 0);
      cycle(1'b1, 1'b1, 1);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 0);
      for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 0);

      // Randomized phases, each ending in a mid-activity reset.
      for (int p = 0; p < 4; p++) begin
         r = 1'b0;
         for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 29) == 0) r = !r;
            v = ($urandom_range(0, 5) == 0);
            d = ($urandom_range(0, 7) == 0) ? $urandom_range(6, 9) : $urandom_range(0, 5);
            cycle(r, v, d);
         end
         for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, $urandom_range(0, 4));
         do_reset();
      end

      // Post-reset: divisor must be back at 100 (no toggle within 100 cycles).
      for (int i = 0; i < 105; i++) cycle(1'b1, 1'b0, 0);

      @(negedge clk_in);
      #1;
      check("scoreboard_drained", W'(sb.size()), '0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
